// File: rtl/serial_deframer_pkg.sv
// Shared definitions for the serial deframer: FSM state encodings, idle line level, parity helper.
package serial_deframer_pkg;

  localparam logic [2:0] SER_IDLE   = 3'd0;
  localparam logic [2:0] SER_DATA   = 3'd1;
  localparam logic [2:0] SER_PARITY = 3'd2;
  localparam logic [2:0] SER_STOP   = 3'd3;
  localparam logic [2:0] SER_BREAK  = 3'd4;

  localparam logic SER_IDLE_LEVEL = 1'b1;

  // Expected parity bit for a data word (zero-extended to 16 bits).
  function automatic logic ser_parity_bit(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_deframer_if.sv
// Serial input and word-output handshake bundle for serial_deframer.
interface serial_deframer_if #(parameter int unsigned N = 8);
  logic         din;
  logic         bit_en;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  modport slave (
    input  din, bit_en, dout_ready,
    output dout, dout_valid, frame_err, overrun, busy
  );

  modport master (
    output din, bit_en, dout_ready,
    input  dout, dout_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_deframer_shift_in.sv
// N-bit LSB-first right-shift register with enable, synchronous clear and async reset.
module ser_shift_in #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_din,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= {i_din, r_q[W-1:1]};
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_deframer.sv
// Serial frame receiver: start detect, N data bits LSB-first, optional parity, stop check,
// one-deep valid/ready output register. Define SER_PARITY_EN to add the parity bit.
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  serial_deframer_if.slave   bus
);

  localparam int unsigned      CW   = $clog2(N);
  localparam logic [CW-1:0]    LAST = CW'(N - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_count;
  logic [N-1:0]  w_sr;
  logic [N-1:0]  r_dout;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;
  logic          w_start;
  logic          w_shift;
  logic          w_stop_smp;
  logic          w_good;
  logic          w_bad;

  assign w_start    = bus.bit_en && (r_state == SER_IDLE) && (bus.din != SER_IDLE_LEVEL);
  assign w_shift    = bus.bit_en && (r_state == SER_DATA);
  assign w_stop_smp = bus.bit_en && (r_state == SER_STOP);

`ifdef SER_PARITY_EN
  logic r_par_err;
  assign w_good = w_stop_smp && (bus.din == SER_IDLE_LEVEL) && !r_par_err;
`else
  assign w_good = w_stop_smp && (bus.din == SER_IDLE_LEVEL);
`endif
  assign w_bad = w_stop_smp && !w_good;

  ser_shift_in #(.W(N)) u_shift (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_shift),
    .i_clr (w_start),
    .i_din (bus.din),
    .o_q   (w_sr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SER_IDLE;
      r_count <= '0;
`ifdef SER_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else if (bus.bit_en) begin
      case (r_state)
        SER_IDLE: begin
          if (bus.din != SER_IDLE_LEVEL) begin
            r_state <= SER_DATA;
            r_count <= '0;
`ifdef SER_PARITY_EN
            r_par_err <= 1'b0;
`endif
          end
        end
        SER_DATA: begin
          if (r_count == LAST) begin
`ifdef SER_PARITY_EN
            r_state <= SER_PARITY;
`else
            r_state <= SER_STOP;
`endif
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
`ifdef SER_PARITY_EN
        SER_PARITY: begin
          r_par_err <= (bus.din != ser_parity_bit(16'(w_sr), PARITY_ODD));
          r_state   <= SER_STOP;
        end
`endif
        SER_STOP:  r_state <= (bus.din == SER_IDLE_LEVEL) ? SER_IDLE : SER_BREAK;
        SER_BREAK: if (bus.din == SER_IDLE_LEVEL) r_state <= SER_IDLE;
        default:   r_state <= SER_IDLE;
      endcase
    end
  end

  // A good word loads when the register is empty or being drained this same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      r_overrun   <= w_good && r_valid && !bus.dout_ready;
      if (w_good && (!r_valid || bus.dout_ready)) begin
        r_dout  <= w_sr;
        r_valid <= 1'b1;
      end else if (r_valid && bus.dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (r_state != SER_IDLE);

endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer (N=8, bit_en one clk in every 4).
module tb_serial_deframer;

  localparam int unsigned N = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  serial_deframer_if #(.N(N)) bus ();

  serial_deframer #(.N(N), .PARITY_ODD(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bit period: din held for 4 clks, bit_en high in the last. Returns at the negedge
  // just after the sampling posedge.
  task automatic strobe(input logic b);
    bus.din    = b;
    bus.bit_en = 1'b0;
    repeat (3) @(negedge clk);
    bus.bit_en = 1'b1;
    @(negedge clk);
    bus.bit_en = 1'b0;
  endtask

  // Start + data LSB-first (+ parity) + stop; optionally raise ready only in the stop-sample cycle.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par,
                            input logic ready_at_stop);
    strobe(1'b0);
    for (int i = 0; i < 8; i++) strobe(data[i]);
`ifdef SER_PARITY_EN
    strobe(par);
`endif
    bus.din    = stop;
    bus.bit_en = 1'b0;
    repeat (3) @(negedge clk);
    bus.bit_en = 1'b1;
    if (ready_at_stop) bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.bit_en = 1'b0;
    if (ready_at_stop) bus.dout_ready = 1'b0;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    bus.din = 1'b1; bus.bit_en = 1'b0; bus.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.dout, bus.dout_valid, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got dout=%h v=%b fe=%b ov=%b busy=%b, want all 0",
               bus.dout, bus.dout_valid, bus.frame_err, bus.overrun, bus.busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bus.dout_ready = 1'b1;
    strobe(1'b0);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    for (int i = 0; i < 8; i++) strobe(logic'((8'hA5 >> i) & 1));
    strobe(1'b1);
    n_tests++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA5 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_word: got v=%b dout=%h fe=%b ov=%b want v=1 dout=a5 fe=0 ov=0",
               bus.dout_valid, bus.dout, bus.frame_err, bus.overrun);
    end
    @(negedge clk);
    n_tests++;
    if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_consume: got v=%b busy=%b want 0 0", bus.dout_valid, bus.busy);
    end
  endtask

  task automatic test_stop_error;
    bus.dout_ready = 1'b1;
    send_frame(8'hA5, 1'b0, even_par(8'hA5), 1'b0);
    n_tests++;
    if (bus.frame_err !== 1'b1 || bus.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL stop_err_pulse: got fe=%b v=%b want fe=1 v=0", bus.frame_err, bus.dout_valid);
    end
    for (int k = 0; k < 3; k++) begin
      strobe(1'b0);
      n_tests++;
      if (bus.busy !== 1'b1 || bus.frame_err !== 1'b0 || bus.dout_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL break_hold: got busy=%b fe=%b v=%b want 1 0 0", bus.busy, bus.frame_err, bus.dout_valid);
      end
    end
    strobe(1'b1);
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL break_exit: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_overrun;
    bus.dout_ready = 1'b0;
    send_frame(8'h3C, 1'b1, even_par(8'h3C), 1'b0);
    strobe(1'b1);
    send_frame(8'hC3, 1'b1, even_par(8'hC3), 1'b0);
    n_tests++;
    if (bus.overrun !== 1'b1 || bus.dout !== 8'h3C || bus.dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got ov=%b dout=%h v=%b want ov=1 dout=3c v=1",
               bus.overrun, bus.dout, bus.dout_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_width: got %b want 0", bus.overrun); end
    strobe(1'b1);
  endtask

  task automatic test_back_to_back;
    send_frame(8'hC3, 1'b1, even_par(8'hC3), 1'b1);
    n_tests++;
    if (bus.dout !== 8'hC3 || bus.dout_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL replace_on_handshake: got dout=%h v=%b ov=%b want dout=c3 v=1 ov=0",
               bus.dout, bus.dout_valid, bus.overrun);
    end
    @(negedge clk);
    n_tests++;
    if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL replace_hold: got v=%b want 1", bus.dout_valid); end
    bus.dout_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL replace_drain: got v=%b want 0", bus.dout_valid); end
    strobe(1'b1);
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity;
    bus.dout_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA5 || bus.frame_err !== 1'b0) begin
      n_fail++; $display("FAIL parity_ok: got v=%b dout=%h fe=%b want 1 a5 0", bus.dout_valid, bus.dout, bus.frame_err);
    end
    strobe(1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (bus.dout_valid !== 1'b0 || bus.frame_err !== 1'b1) begin
      n_fail++; $display("FAIL parity_bad: got v=%b fe=%b want v=0 fe=1", bus.dout_valid, bus.frame_err);
    end
    strobe(1'b1);
  endtask
`endif

  task automatic test_reset_mid_frame;
    bus.dout_ready = 1'b0;
    send_frame(8'h5A, 1'b1, even_par(8'h5A), 1'b0);
    strobe(1'b1);
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.dout, bus.dout_valid, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: got dout=%h v=%b fe=%b ov=%b busy=%b want all 0",
               bus.dout, bus.dout_valid, bus.frame_err, bus.overrun, bus.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.din = 1'b1;
    @(negedge clk);
    send_frame(8'h81, 1'b1, even_par(8'h81), 1'b0);
    n_tests++;
    if (bus.dout !== 8'h81 || bus.dout_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_frame: got dout=%h v=%b fe=%b want 81 1 0", bus.dout, bus.dout_valid, bus.frame_err);
    end
    bus.dout_ready = 1'b1;
    strobe(1'b1);
  endtask

  // Frame-level model: one register slot, a frame is good iff stop=1 and parity matches.
  task automatic test_random;
    logic [7:0] m_dout;
    logic       m_valid;
    m_dout  = bus.dout;
    m_valid = 1'b0;
    for (int f = 0; f < 24; f++) begin
      logic [7:0] d;
      logic       stop, par, rdy, good, exp_ov, exp_fe;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      par  = ($urandom_range(0, 5) != 0) ? even_par(d) : ~even_par(d);
      rdy  = 1'($urandom_range(0, 1));
      good = stop;
`ifdef SER_PARITY_EN
      good = good && (par == even_par(d));
`endif
      bus.dout_ready = rdy;
      if (rdy) m_valid = 1'b0;
      exp_fe = !good;
      exp_ov = good && m_valid;
      if (good && !m_valid) begin
        m_dout  = d;
        m_valid = 1'b1;
      end
      send_frame(d, stop, par, 1'b0);
      n_tests++;
      if (bus.dout !== m_dout || bus.dout_valid !== m_valid || bus.frame_err !== exp_fe ||
          bus.overrun !== exp_ov) begin
        n_fail++;
        $display("FAIL random_frame%0d: got dout=%h v=%b fe=%b ov=%b want dout=%h v=%b fe=%b ov=%b",
                 f, bus.dout, bus.dout_valid, bus.frame_err, bus.overrun, m_dout, m_valid, exp_fe, exp_ov);
      end
      strobe(1'b1);
      if (rdy) m_valid = 1'b0;
      n_tests++;
      if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0 || bus.dout_valid !== m_valid) begin
        n_fail++;
        $display("FAIL random_after%0d: got fe=%b ov=%b busy=%b v=%b want 0 0 0 %b",
                 f, bus.frame_err, bus.overrun, bus.busy, bus.dout_valid, m_valid);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_stop_error();
    test_overrun();
    test_back_to_back();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
